// File: rtl/acc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// acc_seq_ctrl
//
// Sequencer for one binary-serial MAC lane. A job of k_len products is
// accepted from the array scheduler; each operand pair is handshaked in,
// the bit-serial multiplier is run for MUL_CYC cycles, and the product is
// folded into the PE partial-sum accumulator. Once all products are in, the
// result is offered downstream with a valid/ready handshake.
//
// Per-product timing with no operand stall (t = operand handshake cycle):
//   t                : LOAD, in_ready=1, mul_load=1
//   t+1 .. t+MUL_CYC : MUL,  mul_en=1
//   t+MUL_CYC+1      : UPD,  acc_en=1 (acc_sel=1 on the first product)
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   start      job request, sampled only while idle
//   k_len      products in the job, captured on an accepted start
//   in_valid   operand pair available
//   in_ready   controller ready for an operand pair
//   mul_load   one-cycle pulse, multiplier latches operands
//   mul_en     multiplier shift/iterate enable
//   acc_clr    accumulator synchronous clear
//   acc_en     accumulator update enable
//   acc_sel    1 = load product, 0 = hold-and-add
//   out_valid  job result valid at accumulator output
//   out_ready  downstream consumes the result
//   busy       high whenever the controller is not idle
// -----------------------------------------------------------------------------
module acc_seq_ctrl #(
    parameter int K_WIDTH   = 16,
    parameter int MUL_CYC   = 16,
    parameter int CYC_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_WIDTH-1:0] k_len,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mul_load,
    output logic               mul_en,
    output logic               acc_clr,
    output logic               acc_en,
    output logic               acc_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL  = 3'd2,
        S_UPD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_reg;
    logic [K_WIDTH-1:0]   prod_cnt_reg;
    logic [K_WIDTH-1:0]   k_cap_reg;
    logic [CYC_WIDTH-1:0] cyc_cnt_reg;

    // Registered state-decoded outputs. Each flag is written together with
    // the state transition that enters (or leaves) the state it belongs to,
    // so it always equals a pure decode of state_reg.
    logic in_ready_reg;
    logic mul_en_reg;
    logic acc_en_reg;
    logic acc_sel_reg;
    logic out_valid_reg;
    logic busy_reg;

    logic [K_WIDTH-1:0] prod_inc;
    assign prod_inc = prod_cnt_reg + K_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            prod_cnt_reg  <= '0;
            k_cap_reg     <= '0;
            cyc_cnt_reg   <= '0;
            in_ready_reg  <= 1'b0;
            mul_en_reg    <= 1'b0;
            acc_en_reg    <= 1'b0;
            acc_sel_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            // UPD lasts exactly one cycle; its strobes default low.
            acc_en_reg  <= 1'b0;
            acc_sel_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy_reg     <= 1'b1;
                        prod_cnt_reg <= '0;
                        k_cap_reg    <= k_len;
                        if (k_len != '0) begin
                            state_reg    <= S_LOAD;
                            in_ready_reg <= 1'b1;
                        end else begin
                            // Empty job: the cleared accumulator is the result.
                            state_reg     <= S_DONE;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (in_valid) begin
                        state_reg    <= S_MUL;
                        in_ready_reg <= 1'b0;
                        mul_en_reg   <= 1'b1;
                        cyc_cnt_reg  <= CYC_WIDTH'(MUL_CYC - 1);
                    end
                end

                S_MUL: begin
                    if (cyc_cnt_reg == '0) begin
                        state_reg   <= S_UPD;
                        mul_en_reg  <= 1'b0;
                        acc_en_reg  <= 1'b1;
                        // First product of the job overwrites the accumulator.
                        acc_sel_reg <= (prod_cnt_reg == '0);
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg - CYC_WIDTH'(1);
                    end
                end

                S_UPD: begin
                    // prod_cnt < k_cap holds here, so the increment cannot
                    // pass the captured length; the guard keeps it saturating.
                    if (prod_cnt_reg != k_cap_reg) begin
                        prod_cnt_reg <= prod_inc;
                    end
                    if (prod_inc == k_cap_reg) begin
                        state_reg     <= S_DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        state_reg    <= S_LOAD;
                        in_ready_reg <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        state_reg     <= S_IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end

                default: begin
                    state_reg     <= S_IDLE;
                    in_ready_reg  <= 1'b0;
                    mul_en_reg    <= 1'b0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign mul_en    = mul_en_reg;
    assign acc_en    = acc_en_reg;
    assign acc_sel   = acc_sel_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;

    // The two handshake-coupled pulses land in the cycle the request is seen.
    // in_ready_reg is only set in LOAD, so mul_load cannot fire elsewhere.
    // acc_clr is masked by rst so every output is low while reset is held.
    assign mul_load = in_ready_reg & in_valid;
    assign acc_clr  = (state_reg == S_IDLE) & start & ~rst;

endmodule
